// File: rtl/window_3x3_gen_pkg.sv
// window_3x3_gen_pkg: shared types for the 3x3 window generator
package window_3x3_gen_pkg;
  localparam int PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pix_t;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  typedef struct packed {
    pix_t p1, p2, p3, p4, p5, p6, p7, p8, p9;
  } win_t;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// window_3x3_gen_line_buffer: one image line, read-before-write at a shared address
module window_3x3_gen_line_buffer #(
  parameter int DEPTH = 256,
  parameter int W = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o
);
  logic [W-1:0] mem_q [DEPTH];
  assign dout_o = mem_q[addr_i];
  // old contents are read combinationally, new pixel lands at the edge
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= din_i;
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator over a raster pixel stream
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_vld,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] P1,
  output logic [PIX_W-1:0] P2,
  output logic [PIX_W-1:0] P3,
  output logic [PIX_W-1:0] P4,
  output logic [PIX_W-1:0] P5,
  output logic [PIX_W-1:0] P6,
  output logic [PIX_W-1:0] P7,
  output logic [PIX_W-1:0] P8,
  output logic [PIX_W-1:0] P9,
  output logic             win_vld,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_c;
  logic [RW-1:0] row_q, row_d, cur_r;
  logic acc, last_col, end_frame, win_ok;
  logic [PIX_W-1:0] cur_px [3];
  logic [PIX_W-1:0] hist_q [3][2];
  logic [PIX_W-1:0] win_q [9];
  logic win_vld_q, done_q;
  window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .we_i(acc), .addr_i(cur_c), .din_i(pix_in), .dout_o(cur_px[1])
  );
  window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb2 (
    .clk(clk), .we_i(acc), .addr_i(cur_c), .din_i(cur_px[1]), .dout_o(cur_px[0])
  );
  assign cur_px[2] = pix_in;
  // position of the pixel on the input, frame sequencing and window qualification
  always_comb begin
    acc = pix_vld & (sof | (state_q != IDLE));
    cur_c = sof ? '0 : col_q;
    cur_r = sof ? '0 : row_q;
    last_col = cur_c == CW'(IMG_W - 1);
    end_frame = acc & last_col & (cur_r == RW'(IMG_H - 1));
    win_ok = acc & (cur_r >= RW'(2)) & (cur_c >= CW'(2));
    col_d = col_q;
    row_d = row_q;
    state_d = state_q;
    if (acc) begin
      col_d = last_col ? '0 : cur_c + 1'b1;
      row_d = end_frame ? '0 : last_col ? cur_r + 1'b1 : cur_r;
      state_d = end_frame ? IDLE : (row_d >= RW'(2)) ? STREAM : FILL;
    end
  end
  // counters, column history per row and the registered window
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      win_vld_q <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) hist_q[k] <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      win_vld_q <= win_ok;
      done_q <= end_frame;
      if (acc)
        for (int k = 0; k < 3; k++) begin
          hist_q[k][1] <= hist_q[k][0];
          hist_q[k][0] <= cur_px[k];
        end
      if (win_ok)
        for (int k = 0; k < 3; k++) begin
          win_q[3*k]   <= hist_q[k][1];
          win_q[3*k+1] <= hist_q[k][0];
          win_q[3*k+2] <= cur_px[k];
        end
    end
  end
  assign {P1, P2, P3} = {win_q[0], win_q[1], win_q[2]};
  assign {P4, P5, P6} = {win_q[3], win_q[4], win_q[5]};
  assign {P7, P8, P9} = {win_q[6], win_q[7], win_q[8]};
  assign win_vld = win_vld_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: randomized and directed checks against a frame-image reference model
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 0, rst, sof, pix_vld;
  logic [7:0] pix_in;
  logic [7:0] P1, P2, P3, P4, P5, P6, P7, P8, P9;
  logic win_vld, frame_done;
  logic [7:0] dut_p [9];
  int checks = 0, errors = 0;
  int wins = 0, dones = 0;
  logic [7:0] first_win [9];
  logic [7:0] last_p5;
  bit [7:0] img [H][W];
  bit [7:0] e_p [9];
  bit e_vld, e_done, active = 0;
  int idx = 0;
  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_vld(pix_vld), .pix_in(pix_in),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8), .P9(P9),
    .win_vld(win_vld), .frame_done(frame_done)
  );
  assign dut_p = '{P1, P2, P3, P4, P5, P6, P7, P8, P9};
  always #5 clk = ~clk;
  // reference: store accepted pixels into an image by linear frame index, cut windows from it
  always @(posedge clk) begin
    e_vld = 0;
    e_done = 0;
    if (rst) begin
      active = 0;
      idx = 0;
      for (int k = 0; k < 9; k++) e_p[k] = 0;
    end else if (pix_vld && (sof || active)) begin
      int r, c;
      if (sof) idx = 0;
      r = idx / W;
      c = idx % W;
      img[r][c] = pix_in;
      active = 1;
      if (r >= 2 && c >= 2) begin
        e_vld = 1;
        for (int k = 0; k < 9; k++) e_p[k] = img[r-2+k/3][c-2+k%3];
      end
      idx++;
      if (idx == W * H) begin
        active = 0;
        e_done = 1;
      end
    end
    #1;
    checks++;
    if (win_vld !== e_vld) begin
      errors++;
      $display("FAIL win_vld t=%0t got %b expected %b", $time, win_vld, e_vld);
    end
    checks++;
    if (frame_done !== e_done) begin
      errors++;
      $display("FAIL frame_done t=%0t got %b expected %b", $time, frame_done, e_done);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (dut_p[k] !== e_p[k]) begin
        errors++;
        $display("FAIL P%0d t=%0t got %h expected %h", k + 1, $time, dut_p[k], e_p[k]);
      end
    end
    if (win_vld === 1'b1) begin
      if (wins == 0) first_win = dut_p;
      wins++;
      last_p5 = P5;
    end
    if (frame_done === 1'b1) dones++;
  end
  task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic r = 1'b0);
    @(negedge clk);
    rst = r;
    sof = s;
    pix_vld = v;
    pix_in = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask
  task automatic send_frame(input int gap_pct, input bit rnd, input logic [7:0] xr);
    for (int i = 0; i < W * H; i++) begin
      drive(i == 0, 1'b1, rnd ? 8'($urandom) : 8'(((i / W) << 4) | (i % W)) ^ xr);
      if ($urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 8'($urandom));
    end
  endtask
  task automatic check_counts(input string name, input int ew, input int ed);
    checks++;
    if (wins !== ew) begin
      errors++;
      $display("FAIL %s windows got %0d expected %0d", name, wins, ew);
    end
    checks++;
    if (dones !== ed) begin
      errors++;
      $display("FAIL %s frame_done pulses got %0d expected %0d", name, dones, ed);
    end
    wins = 0;
    dones = 0;
  endtask
  task automatic test_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if ({P1, P2, P3, P4, P5, P6, P7, P8, P9, win_vld, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h expected 0", {P1, P2, P3, P4, P5, P6, P7, P8, P9, win_vld, frame_done});
    end
    wins = 0;
    dones = 0;
  endtask
  task automatic test_basic();
    logic [7:0] exp_first [9];
    exp_first = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    send_frame(0, 0, 8'h00);
    idle(3);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (first_win[k] !== exp_first[k]) begin
        errors++;
        $display("FAIL basic first P%0d got %h expected %h", k + 1, first_win[k], exp_first[k]);
      end
    end
    checks++;
    if (last_p5 !== 8'h23) begin
      errors++;
      $display("FAIL basic last P5 got %h expected 23", last_p5);
    end
    check_counts("basic", 6, 1);
  endtask
  task automatic test_gapped();
    send_frame(100, 0, 8'h00);
    idle(3);
    check_counts("gapped", 6, 1);
  endtask
  task automatic test_garbage();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom));
    send_frame(0, 0, 8'h00);
    idle(3);
    checks++;
    if (first_win[8] !== 8'h22) begin
      errors++;
      $display("FAIL garbage first P9 got %h expected 22", first_win[8]);
    end
    check_counts("garbage", 6, 1);
  endtask
  task automatic test_abort();
    for (int i = 0; i < 2 * W + 3; i++) drive(i == 0, 1'b1, 8'(((i / W) << 4) | (i % W)));
    send_frame(0, 0, 8'h40);
    idle(3);
    check_counts("abort", 7, 1);
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3 * W + 1; i++) drive(i == 0, 1'b1, 8'(((i / W) << 4) | (i % W)));
    drive(1'b0, 1'b1, 8'h31, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if ({P1, P2, P3, P4, P5, P6, P7, P8, P9, win_vld, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h expected 0", {P1, P2, P3, P4, P5, P6, P7, P8, P9, win_vld, frame_done});
    end
    wins = 0;
    dones = 0;
    for (int i = 0; i < W * H; i++) drive(1'b0, 1'b1, 8'($urandom));
    idle(2);
    check_counts("reset_mid_drop", 0, 0);
    send_frame(0, 0, 8'h11);
    idle(3);
    check_counts("reset_mid_recover", 6, 1);
  endtask
  task automatic test_back_to_back();
    send_frame(0, 0, 8'h00);
    send_frame(0, 0, 8'h80);
    idle(3);
    check_counts("back_to_back", 12, 2);
  endtask
  task automatic test_random();
    for (int f = 0; f < 4; f++) send_frame(30, 1, 8'h00);
    idle(3);
    check_counts("random", 24, 4);
  endtask
  initial begin
    rst = 1;
    sof = 0;
    pix_vld = 0;
    pix_in = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_garbage();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
